replay_ififo: RTL and testbench
===============================

REPLAY_IFIFO -- requirements
Module: replay_ififo

Interface
REQ-001 SHALL have parameter col, default 8, meaning the number of lanes per word.
REQ-002 SHALL have parameter bw, default 4, meaning the bit width of each lane.
REQ-003 SHALL have parameter depth, default 64, meaning the FIFO entries; it SHALL be a power of two, at least 2.
REQ-004 SHALL have parameter rep_bw, default 8, meaning the width of the replay-count port.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port clear  in  1  synchronous flush.
REQ-008 SHALL have port wr  in  1  write request.
REQ-009 SHALL have port in  in  col*bw  write data.
REQ-010 SHALL have port rd  in  1  read request.
REQ-011 SHALL have port out  out  col*bw  registered read data.
REQ-012 SHALL have port o_valid  out  1  out holds a freshly read word this cycle.
REQ-013 SHALL have port start  in  1  begin a replay session.
REQ-014 SHALL have port replay_num  in  rep_bw  number of passes, sampled when start is accepted.
REQ-015 SHALL have port o_full, o_empty  out  1 each  occupancy flags.
REQ-016 SHALL have port o_level  out  log2(depth)+1  current occupancy.
REQ-017 SHALL have port o_busy  out  1  replay session active.
REQ-018 SHALL have port o_done  out  1  one-cycle pulse when a session ends.
REQ-019 SHALL have port o_wr_err  out  1  sticky flag for a dropped write.

Function
REQ-020 SHALL implement a two-state FSM: LOAD (the default) and REPLAY.
REQ-021 In LOAD, SHALL behave as a standard FIFO:
- wr is accepted when not full;
- rd is accepted when not empty;
- with simultaneous wr and rd, both SHALL be accepted when full, and only the write when empty.
REQ-022 An accepted rd SHALL present the head word on out after the same clock edge, with o_valid high for exactly that cycle; o_valid SHALL be low in all other cycles.
REQ-023 When rd is not accepted, out SHALL hold its previous value.
REQ-024 In LOAD, start SHALL be accepted only if the FIFO is not empty.
- On acceptance: latch base = rd pointer, end = wr pointer, passes = max(replay_num, 1); enter REPLAY next cycle.
- start while empty SHALL be ignored.
REQ-025 In REPLAY, each accepted rd SHALL advance a replay pointer from base toward end, without freeing entries; o_level and o_empty SHALL stay constant.
REQ-026 On the read of the last entry (end-1) in REPLAY:
- if passes > 1, the replay pointer SHALL rewind to base and passes SHALL decrement, with no bubble;
- if passes == 1, all replayed entries SHALL be freed (rd pointer = end, level reduced accordingly), o_done SHALL pulse the following cycle, and the FSM SHALL return to LOAD.
REQ-027 In REPLAY, wr SHALL be accepted into free entries beyond end.
- These words SHALL NOT be replayed; they remain in the FIFO after the session.
- A wr while full SHALL be dropped and SHALL set o_wr_err.
REQ-028 In LOAD, a wr while full (without simultaneous rd) SHALL be dropped and SHALL set o_wr_err.
REQ-029 o_wr_err SHALL be cleared only by reset or clear.
REQ-030 start while in REPLAY SHALL be ignored.
REQ-031 Pointers SHALL wrap modulo depth. A session spanning the wrap point, where end is less than base numerically, SHALL replay in order.
REQ-032 A full FIFO (end == base) SHALL replay all depth entries per pass.
REQ-033 clear SHALL, on the next edge:
- empty the FIFO and return to LOAD;
- zero o_level and deassert o_busy, o_valid and o_wr_err;
- not pulse o_done.
clear SHALL override wr, rd and start in the same cycle.
REQ-034 o_full SHALL equal (level == depth); o_empty SHALL equal (level == 0); o_busy SHALL be high exactly in REPLAY.

Reset
REQ-035 While reset is high, regardless of clk:
- pointers and level SHALL be 0, state SHALL be LOAD, and passes SHALL be 0;
- out SHALL be 0;
- o_valid, o_busy, o_done and o_wr_err SHALL be 0;
- o_empty SHALL be 1 and o_full SHALL be 0.
REQ-036 Reset asserted mid-session SHALL abort the session with no o_done pulse; storage contents need not be cleared.

Structure
REQ-037 The FSM state encoding (LOAD, REPLAY) and the pointer-width helper constant SHALL reside in the shared corelet package.
REQ-038 Storage SHALL be one sub-module, fifo_mem: depth x (col*bw), with one synchronous write port and one registered read port, no reset on the array.
REQ-039 The FSM, pointers and counters SHALL live in replay_ififo.

Verification
REQ-040 Write 4 words (A..D), rd x4 in LOAD -> out = A,B,C,D on consecutive cycles, o_valid high 4 cycles, o_empty = 1 afterwards.
REQ-041 Write A,B,C; start with replay_num = 3; rd held high -> out = A,B,C,A,B,C,A,B,C with no gaps, o_done one cycle after the final C, level 3 -> 0.
REQ-042 replay_num = 0 with 2 words loaded -> exactly one pass, then o_done.
REQ-043 depth = 8: fill 8, read 6, write 6 (wrapped), start with replay_num = 2 -> 16 outputs in order; a wr during the session sets o_wr_err and drops the write.
REQ-044 During REPLAY of 3 words, write X -> X is not replayed; after o_done, level = 1 and the next rd returns X.
REQ-045 Mid-session clear -> next cycle level = 0, o_busy = 0, no o_done; asynchronous reset asserted between clock edges -> outputs reach reset values immediately.

Source files
------------

// File: rtl/replay_ififo_pkg.sv
// ============================================================================
// replay_ififo_pkg : shared FSM encoding and pointer-width helper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package replay_ififo_pkg;

   typedef enum logic [0:0] {
      LOAD   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   // Pointer width for a power-of-two depth (depth >= 2)
   function automatic int ptr_w(input int d);
      return (d > 2) ? $clog2(d) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/replay_ififo_fifo_mem.sv
// ============================================================================
// fifo_mem : depth x width storage, synchronous write, registered read port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   // Same-edge write to the read address returns the old word (full wr+rd case)
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= r_mem[raddr];
   end

endmodule

`default_nettype wire

// File: rtl/replay_ififo.sv
// ============================================================================
// replay_ififo : FIFO that can replay its current contents N times before
//                releasing them; FSM, pointers and counters live here.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module replay_ififo
   import replay_ififo_pkg::*;
#(
   parameter int col    = 8,
   parameter int bw     = 4,
   parameter int depth  = 64,
   parameter int rep_bw = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       wr,
   input  logic [col*bw-1:0]          in,
   input  logic                       rd,
   output logic [col*bw-1:0]          out,
   output logic                       o_valid,
   input  logic                       start,
   input  logic [rep_bw-1:0]          replay_num,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [ptr_w(depth):0]      o_level,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_wr_err
);

   localparam int AW = ptr_w(depth);
   localparam int LW = AW + 1;

   state_t            r_state,  w_state_nx;
   logic [AW-1:0]     r_rd_ptr, w_rd_ptr_nx;
   logic [AW-1:0]     r_wr_ptr, w_wr_ptr_nx;
   logic [AW-1:0]     r_base,   w_base_nx;
   logic [AW-1:0]     r_end,    w_end_nx;
   logic [AW-1:0]     r_rep,    w_rep_nx;
   logic [LW-1:0]     r_level,  w_level_nx;
   logic [LW-1:0]     r_count,  w_count_nx;
   logic [rep_bw-1:0] r_passes, w_passes_nx;
   logic              r_valid,  w_valid_nx;
   logic              r_done,   w_done_nx;
   logic              r_wr_err, w_wr_err_nx;

   logic              w_full, w_empty, w_rd_ok, w_wr_ok, w_start_ok, w_last;
   logic [AW-1:0]     w_rd_addr;

   assign w_full  = (r_level == LW'(depth));
   assign w_empty = (r_level == '0);
   assign w_last  = (r_rep == AW'(r_end - AW'(1)));

   // Accept logic; a read is held off in the start cycle so base/end latch cleanly
   always_comb begin
      w_start_ok = 1'b0;
      w_rd_ok    = 1'b0;
      w_wr_ok    = 1'b0;
      if (!clear) begin
         if (r_state == LOAD) begin
            w_start_ok = start && !w_empty;
            w_rd_ok    = rd && !w_empty && !w_start_ok;
            w_wr_ok    = wr && (!w_full || w_rd_ok);
         end else begin
            w_rd_ok    = rd;
            w_wr_ok    = wr && !w_full;
         end
      end
   end

   assign w_rd_addr = (r_state == REPLAY) ? r_rep : r_rd_ptr;

   always_comb begin
      w_state_nx  = r_state;
      w_rd_ptr_nx = r_rd_ptr;
      w_wr_ptr_nx = r_wr_ptr;
      w_base_nx   = r_base;
      w_end_nx    = r_end;
      w_rep_nx    = r_rep;
      w_level_nx  = r_level;
      w_count_nx  = r_count;
      w_passes_nx = r_passes;
      w_valid_nx  = 1'b0;
      w_done_nx   = 1'b0;
      w_wr_err_nx = r_wr_err;

      if (clear) begin
         w_state_nx  = LOAD;
         w_rd_ptr_nx = '0;
         w_wr_ptr_nx = '0;
         w_level_nx  = '0;
         w_passes_nx = '0;
         w_wr_err_nx = 1'b0;
      end else begin
         w_valid_nx = w_rd_ok;
         if (wr && !w_wr_ok) w_wr_err_nx = 1'b1;
         if (w_wr_ok)        w_wr_ptr_nx = r_wr_ptr + AW'(1);

         case (r_state)
            LOAD: begin
               w_level_nx = r_level + LW'(w_wr_ok) - LW'(w_rd_ok);
               if (w_rd_ok) w_rd_ptr_nx = r_rd_ptr + AW'(1);
               if (w_start_ok) begin
                  w_state_nx  = REPLAY;
                  w_base_nx   = r_rd_ptr;
                  w_end_nx    = r_wr_ptr;
                  w_rep_nx    = r_rd_ptr;
                  w_count_nx  = r_level;
                  w_passes_nx = (replay_num == '0) ? rep_bw'(1) : replay_num;
               end
            end
            REPLAY: begin
               w_level_nx = r_level + LW'(w_wr_ok);
               if (w_rd_ok) begin
                  if (!w_last) begin
                     w_rep_nx = r_rep + AW'(1);
                  end else if (r_passes > rep_bw'(1)) begin
                     w_rep_nx    = r_base;
                     w_passes_nx = r_passes - rep_bw'(1);
                  end else begin
                     // Final pass done: release the whole replayed window
                     w_rd_ptr_nx = r_end;
                     w_level_nx  = r_level - r_count + LW'(w_wr_ok);
                     w_passes_nx = '0;
                     w_state_nx  = LOAD;
                     w_done_nx   = 1'b1;
                  end
               end
            end
            default: w_state_nx = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= LOAD;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_base   <= '0;
         r_end    <= '0;
         r_rep    <= '0;
         r_level  <= '0;
         r_count  <= '0;
         r_passes <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_wr_err <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_rd_ptr <= w_rd_ptr_nx;
         r_wr_ptr <= w_wr_ptr_nx;
         r_base   <= w_base_nx;
         r_end    <= w_end_nx;
         r_rep    <= w_rep_nx;
         r_level  <= w_level_nx;
         r_count  <= w_count_nx;
         r_passes <= w_passes_nx;
         r_valid  <= w_valid_nx;
         r_done   <= w_done_nx;
         r_wr_err <= w_wr_err_nx;
      end
   end

   fifo_mem #(
      .WIDTH (col*bw),
      .DEPTH (depth),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (w_wr_ok),
      .waddr (r_wr_ptr),
      .wdata (in),
      .re    (w_rd_ok),
      .raddr (w_rd_addr),
      .rdata (out)
   );

   assign o_valid  = r_valid;
   assign o_full   = w_full;
   assign o_empty  = w_empty;
   assign o_level  = r_level;
   assign o_busy   = (r_state == REPLAY);
   assign o_done   = r_done;
   assign o_wr_err = r_wr_err;

endmodule

`default_nettype wire

// File: tb/tb_replay_ififo.sv
// ============================================================================
// tb_replay_ififo : directed self-checking bench for replay_ififo (depth 8)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_replay_ififo;

   localparam int COL = 8;
   localparam int BW  = 4;
   localparam int DEP = 8;
   localparam int REP = 8;
   localparam int W   = COL*BW;

   logic           clk = 1'b0;
   logic           reset, clear, wr, rd, start;
   logic [W-1:0]   din, dout;
   logic [REP-1:0] replay_num;
   logic           o_valid, o_full, o_empty, o_busy, o_done, o_wr_err;
   logic [3:0]     o_level;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] seq [16];

   replay_ififo #(.col(COL), .bw(BW), .depth(DEP), .rep_bw(REP)) dut (
      .clk(clk), .reset(reset), .clear(clear), .wr(wr), .in(din), .rd(rd),
      .out(dout), .o_valid(o_valid), .start(start), .replay_num(replay_num),
      .o_full(o_full), .o_empty(o_empty), .o_level(o_level), .o_busy(o_busy),
      .o_done(o_done), .o_wr_err(o_wr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] word);
      wr  = 1'b1;
      din = word;
      tick();
      wr  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; wr = 1'b0; rd = 1'b0; start = 1'b0;
      din = '0; replay_num = '0;
      repeat (2) tick();
      check("rst_out",   dout,     0);
      check("rst_valid", o_valid,  0);
      check("rst_empty", o_empty,  1);
      check("rst_full",  o_full,   0);
      check("rst_level", o_level,  0);
      check("rst_busy",  o_busy,   0);
      check("rst_done",  o_done,   0);
      check("rst_err",   o_wr_err, 0);
      reset = 1'b0;
      tick();

      // Plain FIFO: A..D in, A..D out
      for (int i = 0; i < 4; i++) push(32'hA000_0000 + i);
      check("t1_level4", o_level, 4);
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t1_out",   dout,    32'hA000_0000 + i);
         check("t1_valid", o_valid, 1);
      end
      rd = 1'b0;
      tick();
      check("t1_valid_lo", o_valid, 0);
      check("t1_empty",    o_empty, 1);
      check("t1_hold",     dout,    32'hA000_0003);
      rd = 1'b1;
      tick();
      check("rd_empty_valid", o_valid, 0);
      check("rd_empty_hold",  dout,    32'hA000_0003);
      rd = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_empty_busy", o_busy, 0);

      // Three words replayed three times
      for (int i = 0; i < 3; i++) push(32'hB000_0000 + i);
      replay_num = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2_busy",  o_busy,  1);
      check("t2_level", o_level, 3);
      rd = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         check("t2_out",   dout,    32'hB000_0000 + (i % 3));
         check("t2_valid", o_valid, 1);
         if (i < 8) begin
            check("t2_done_lo", o_done,  0);
            check("t2_lvl_mid", o_level, 3);
         end else begin
            check("t2_done",    o_done,  1);
            check("t2_lvl_end", o_level, 0);
            check("t2_busy_lo", o_busy,  0);
         end
      end
      rd = 1'b0;
      tick();
      check("t2_done_pulse", o_done,  0);
      check("t2_empty",      o_empty, 1);

      // replay_num = 0 behaves as a single pass
      push(32'hC000_0000);
      push(32'hC000_0001);
      replay_num = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      rd = 1'b1;
      tick();
      check("t3_out0",  dout,   32'hC000_0000);
      check("t3_done0", o_done, 0);
      tick();
      check("t3_out1",  dout,   32'hC000_0001);
      check("t3_done1", o_done, 1);
      rd = 1'b0;
      tick();
      check("t3_busy", o_busy, 0);
      check("t3_done_lo", o_done, 0);

      // Word written during replay stays behind for a normal read
      for (int i = 0; i < 3; i++) push(32'hD000_0000 + i);
      replay_num = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      rd = 1'b1; wr = 1'b1; din = 32'hDEAD_BEEF;
      tick();
      wr = 1'b0;
      check("t4_out0",  dout,    32'hD000_0000);
      check("t4_level", o_level, 4);
      tick();
      check("t4_out1",  dout,    32'hD000_0001);
      tick();
      check("t4_out2",  dout,    32'hD000_0002);
      check("t4_done",  o_done,  1);
      check("t4_lvl1",  o_level, 1);
      tick();
      check("t4_outX",  dout,    32'hDEAD_BEEF);
      check("t4_empty", o_empty, 1);
      rd = 1'b0;
      tick();

      // Wrapped full session replayed twice, write during session dropped
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 8; i++) push(32'hF000_0000 + i);
      check("t5_full", o_full, 1);
      rd = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t5_pre", dout, 32'hF000_0000 + i);
      end
      rd = 1'b0;
      check("t5_lvl2", o_level, 2);
      for (int i = 0; i < 6; i++) push(32'h6000_0000 + i);
      check("t5_full2", o_full, 1);
      seq[0] = 32'hF000_0006;
      seq[1] = 32'hF000_0007;
      for (int i = 0; i < 6; i++) seq[i+2] = 32'h6000_0000 + i;
      replay_num = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      rd = 1'b1; wr = 1'b1; din = 32'h0BAD_0BAD;
      for (int i = 0; i < 16; i++) begin
         tick();
         wr = 1'b0;
         check("t5_out", dout, seq[i % 8]);
         if (i == 0)  check("t5_err",     o_wr_err, 1);
         if (i < 15)  check("t5_lvl8",    o_level,  8);
         if (i == 15) check("t5_done",    o_done,   1);
         if (i == 15) check("t5_lvl_end", o_level,  0);
      end
      rd = 1'b0;
      tick();
      check("t5_empty",  o_empty,  1);
      check("t5_sticky", o_wr_err, 1);

      // Mid-session clear
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t6_err_clr", o_wr_err, 0);
      for (int i = 0; i < 3; i++) push(32'h7000_0000 + i);
      replay_num = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      rd = 1'b1;
      tick();
      tick();
      check("t6_out1", dout, 32'h7000_0001);
      clear = 1'b1;
      tick();
      check("t6_level", o_level, 0);
      check("t6_busy",  o_busy,  0);
      check("t6_done",  o_done,  0);
      check("t6_valid", o_valid, 0);
      check("t6_empty", o_empty, 1);
      clear = 1'b0; rd = 1'b0;
      tick();
      check("t6_done2", o_done, 0);

      // Asynchronous reset between edges during a session
      for (int i = 0; i < 3; i++) push(32'h8000_0000 + i);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      replay_num = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("t7_out",   dout,    32'h8000_0001);
      check("t7_valid", o_valid, 1);
      check("t7_busy",  o_busy,  1);
      #2;
      reset = 1'b1;
      #1;
      check("t7_rst_out",   dout,    0);
      check("t7_rst_valid", o_valid, 0);
      check("t7_rst_busy",  o_busy,  0);
      check("t7_rst_level", o_level, 0);
      check("t7_rst_empty", o_empty, 1);
      check("t7_rst_full",  o_full,  0);
      tick();
      reset = 1'b0;
      tick();
      check("t7_no_done", o_done, 0);
      check("t7_idle",    o_busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
